// File: rtl/phy_prog_if.sv
// Command, write-stream and pad-side signal bundle of the NAND program PHY.
// The master side drives commands, write data and R/B_n; the slave side is the PHY.
interface phy_prog_if;
    logic        o_cmd_ready;
    logic        i_cmd_valid;
    logic [15:0] i_cmd;
    logic [15:0] i_cmd_id;
    logic [47:0] i_addr;
    logic [31:0] i_cmd_param;
    logic [1:0]  o_status;
    logic        o_done;
    logic [15:0] o_done_id;
    logic        i_wvalid;
    logic        o_wready;
    logic [31:0] i_wdata;
    logic        io_busy;
    logic        o_ce_n;
    logic        o_we_n;
    logic        o_cle;
    logic        o_ale;
    logic [3:0]  o_re;
    logic        i_rb_n;
    logic        o_dqs_tri_en;
    logic        o_dq_tri_en;
    logic [3:0]  o_dqs;
    logic [31:0] o_dq;

    modport master (
        input  o_cmd_ready, o_status, o_done, o_done_id, o_wready, io_busy,
               o_ce_n, o_we_n, o_cle, o_ale, o_re, o_dqs_tri_en, o_dq_tri_en,
               o_dqs, o_dq,
        output i_cmd_valid, i_cmd, i_cmd_id, i_addr, i_cmd_param, i_wvalid,
               i_wdata, i_rb_n
    );

    modport slave (
        output o_cmd_ready, o_status, o_done, o_done_id, o_wready, io_busy,
               o_ce_n, o_we_n, o_cle, o_ale, o_re, o_dqs_tri_en, o_dq_tri_en,
               o_dqs, o_dq,
        input  i_cmd_valid, i_cmd, i_cmd_id, i_addr, i_cmd_param, i_wvalid,
               i_wdata, i_rb_n
    );
endinterface

// File: rtl/phy_prog.sv
// NAND NV-DDR program-direction PHY sequencer: CMD1, address cycles, DQS-driven
// data input, optional CMD2 and a fixed or R/B_n-tracked busy phase.
//
// state | meaning
// IDLE  | waiting for a command descriptor
// CMD1  | first command cycle (CLE)
// ADDR  | address cycles, one byte per latch edge (ALE)
// WPRE  | DQS write preamble, driven low
// DATA  | program data words, one per stream handshake
// WPST  | DQS write postamble, driven low
// CMD2  | confirm command cycle (CLE)
// BUSY  | fixed busy count, or single hop into LOCK
// LOCK  | bus released, waiting for R/B_n to fall
// WAIT  | bus released, waiting for R/B_n to rise
module phy_prog #(
    parameter int DATA_WIDTH = 32,
    parameter int T_CMD_ADDR = 8,
    parameter int T_WPRE     = 4,
    parameter int T_WPST     = 4
) (
    input logic       clk,
    input logic       rst_n,
    phy_prog_if.slave bus
);
    localparam int CA_W = $clog2(T_CMD_ADDR);
    localparam logic [CA_W-1:0] CA_LAST   = CA_W'(T_CMD_ADDR - 1);
    localparam logic [CA_W-1:0] CA_HALF   = CA_W'(T_CMD_ADDR / 2);
    localparam logic [7:0]      WPRE_LAST = 8'(T_WPRE - 1);
    localparam logic [7:0]      WPST_LAST = 8'(T_WPST - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD1, S_ADDR, S_WPRE, S_DATA, S_WPST, S_CMD2, S_BUSY, S_LOCK, S_WAIT
    } state_t;

    state_t          state;
    logic [CA_W-1:0] ca_cnt;
    logic [7:0]      ph_cnt;
    logic [15:0]     cmd_q;
    logic [15:0]     id_q;
    logic [47:0]     addr_sh;
    logic            has_cmd2;
    logic            busy_track;
    logic [2:0]      addr_left;
    logic [10:0]     busy_cnt;
    logic [14:0]     data_bytes;
    logic [15:0]     data_cnt;

    logic            wr_hs;
    logic            ca_state;
    logic            ca_last;
    logic            data_last;
    logic [7:0]      ca_byte;
    state_t          post_addr;
    state_t          post_wpst;
    logic            unused_param;

    assign wr_hs        = (state == S_DATA) && bus.i_wvalid;
    assign ca_state     = state inside {S_CMD1, S_ADDR, S_CMD2};
    assign ca_last      = (ca_cnt == CA_LAST);
    // Partial last word still counts as a whole word
    assign data_last    = ({1'b0, data_cnt} + 17'd4) >= {2'b00, data_bytes};
    assign ca_byte      = (state == S_CMD1) ? cmd_q[7:0] :
                          (state == S_CMD2) ? cmd_q[15:8] : addr_sh[7:0];
    assign post_wpst    = has_cmd2 ? S_CMD2 : S_BUSY;
    assign post_addr    = (data_bytes != 15'd0) ? S_WPRE : post_wpst;
    assign unused_param = bus.i_cmd_param[31];

    assign bus.o_wready = (state == S_DATA);
    assign bus.o_re     = 4'hf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            ca_cnt           <= '0;
            ph_cnt           <= '0;
            cmd_q            <= '0;
            id_q             <= '0;
            addr_sh          <= '0;
            has_cmd2         <= 1'b0;
            busy_track       <= 1'b0;
            addr_left        <= '0;
            busy_cnt         <= '0;
            data_bytes       <= '0;
            data_cnt         <= '0;
            bus.o_cmd_ready  <= 1'b0;
            bus.o_status     <= 2'd0;
            bus.o_done       <= 1'b0;
            bus.o_done_id    <= '0;
            bus.io_busy      <= 1'b0;
            bus.o_ce_n       <= 1'b1;
            bus.o_we_n       <= 1'b1;
            bus.o_cle        <= 1'b0;
            bus.o_ale        <= 1'b0;
            bus.o_dqs        <= 4'hf;
            bus.o_dqs_tri_en <= 1'b1;
            bus.o_dq_tri_en  <= 1'b1;
            bus.o_dq         <= '0;
        end else begin
            bus.o_cmd_ready  <= (state == S_IDLE) && !bus.i_cmd_valid;
            bus.o_ce_n       <= ((state == S_IDLE) && !bus.i_cmd_valid) ||
                                (state == S_LOCK) || (state == S_WAIT);
            bus.io_busy      <= !(state inside {S_IDLE, S_LOCK, S_WAIT});
            bus.o_status     <= (state == S_IDLE) ? 2'd0 :
                                (state inside {S_LOCK, S_WAIT}) ? 2'd2 : 2'd1;
            bus.o_cle        <= state inside {S_CMD1, S_CMD2};
            bus.o_ale        <= (state == S_ADDR);
            bus.o_we_n       <= ca_state ? (ca_cnt >= CA_HALF) : 1'b1;
            bus.o_dq_tri_en  <= !(ca_state || (state inside {S_WPRE, S_DATA, S_WPST}));
            bus.o_dqs_tri_en <= !(state inside {S_WPRE, S_DATA, S_WPST});
            bus.o_done       <= 1'b0;

            if (ca_state) begin
                bus.o_dq  <= {4{ca_byte}};
                bus.o_dqs <= 4'hf;
            end else if (state == S_DATA) begin
                // A stall parks DQS at its last phase level with DQ frozen
                if (wr_hs) begin
                    bus.o_dq  <= bus.i_wdata[DATA_WIDTH-1:0];
                    bus.o_dqs <= 4'h5;
                end else begin
                    bus.o_dqs <= {4{bus.o_dqs[3]}};
                end
            end else if (state inside {S_WPRE, S_WPST}) begin
                bus.o_dq  <= '0;
                bus.o_dqs <= 4'h0;
            end else begin
                bus.o_dq  <= '0;
                bus.o_dqs <= 4'hf;
            end

            case (state)
                S_IDLE: begin
                    if (bus.i_cmd_valid && bus.o_cmd_ready) begin
                        cmd_q      <= bus.i_cmd;
                        id_q       <= bus.i_cmd_id;
                        addr_sh    <= bus.i_addr;
                        has_cmd2   <= bus.i_cmd_param[0];
                        addr_left  <= bus.i_cmd_param[3:1];
                        busy_track <= bus.i_cmd_param[15];
                        busy_cnt   <= bus.i_cmd_param[14:4];
                        data_bytes <= bus.i_cmd_param[30:16];
                        ca_cnt     <= '0;
                        ph_cnt     <= '0;
                        data_cnt   <= '0;
                        state      <= S_CMD1;
                    end
                end
                S_CMD1: begin
                    if (ca_last) begin
                        ca_cnt <= '0;
                        state  <= (addr_left != 3'd0) ? S_ADDR : post_addr;
                    end else begin
                        ca_cnt <= ca_cnt + 1'b1;
                    end
                end
                S_ADDR: begin
                    if (ca_last) begin
                        ca_cnt  <= '0;
                        addr_sh <= addr_sh >> 8;
                        if (addr_left <= 3'd1) begin
                            state <= post_addr;
                        end else begin
                            addr_left <= addr_left - 1'b1;
                        end
                    end else begin
                        ca_cnt <= ca_cnt + 1'b1;
                    end
                end
                S_WPRE: begin
                    if (ph_cnt == WPRE_LAST) begin
                        ph_cnt <= '0;
                        state  <= S_DATA;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (wr_hs) begin
                        data_cnt <= data_cnt + 16'd4;
                        if (data_last) begin
                            state <= S_WPST;
                        end
                    end
                end
                S_WPST: begin
                    if (ph_cnt == WPST_LAST) begin
                        ph_cnt <= '0;
                        state  <= post_wpst;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                S_CMD2: begin
                    if (ca_last) begin
                        ca_cnt <= '0;
                        state  <= S_BUSY;
                    end else begin
                        ca_cnt <= ca_cnt + 1'b1;
                    end
                end
                S_BUSY: begin
                    // A zero fixed count still spends one clock here
                    if (busy_track) begin
                        state <= S_LOCK;
                    end else if (busy_cnt <= 11'd1) begin
                        state         <= S_IDLE;
                        bus.o_done    <= 1'b1;
                        bus.o_done_id <= id_q;
                    end else begin
                        busy_cnt <= busy_cnt - 1'b1;
                    end
                end
                S_LOCK: begin
                    if (!bus.i_rb_n) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.i_rb_n) begin
                        state         <= S_IDLE;
                        bus.o_done    <= 1'b1;
                        bus.o_done_id <= id_q;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_phy_prog.sv
// Directed self-checking bench for phy_prog: program, stall, erase, fixed busy,
// mid-page reset and odd byte count, with a negedge monitor of the pad side.
module tb_phy_prog;
    logic clk;
    logic rst_n;

    phy_prog_if bus_if ();

    phy_prog #(
        .DATA_WIDTH(32),
        .T_CMD_ADDR(8),
        .T_WPRE    (4),
        .T_WPST    (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    localparam logic [63:0] RST_OUT = {28'd0, 1'b0, 2'd0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1,
                                       1'b0, 1'b0, 4'hf, 4'hf, 1'b1, 1'b1, 1'b0};

    int errors = 0;
    int checks = 0;

    logic [31:0] words [0:7];
    int          acc;
    bit          ok;

    int          ale_cyc, busy_cyc, done_cnt;
    logic [15:0] last_id;
    bit          wready_seen, dqs_drive_seen, stat2_seen;
    logic [7:0]  addr_q [$];
    logic [7:0]  cmd_q [$];
    logic [31:0] data_q [$];
    int          clr_gen = 0;
    int          seen_gen = -1;
    logic        prev_we;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack_out();
        return {28'd0, bus_if.o_cmd_ready, bus_if.o_status, bus_if.o_done, bus_if.o_done_id,
                bus_if.io_busy, bus_if.o_ce_n, bus_if.o_we_n, bus_if.o_cle, bus_if.o_ale,
                bus_if.o_re, bus_if.o_dqs, bus_if.o_dqs_tri_en, bus_if.o_dq_tri_en,
                bus_if.o_wready};
    endfunction

    // Pad-side monitor, cleared whenever clr_gen moves
    initial begin
        prev_we = 1'b1;
        forever begin
            @(negedge clk);
            if (clr_gen != seen_gen) begin
                seen_gen = clr_gen;
                ale_cyc = 0; busy_cyc = 0; done_cnt = 0; last_id = '0;
                wready_seen = 0; dqs_drive_seen = 0; stat2_seen = 0;
                addr_q.delete(); cmd_q.delete(); data_q.delete();
            end else begin
                if (bus_if.o_ale) ale_cyc++;
                if (bus_if.io_busy && bus_if.o_dq_tri_en && !bus_if.o_ce_n) busy_cyc++;
                if (!prev_we && bus_if.o_we_n && bus_if.o_ale) addr_q.push_back(bus_if.o_dq[7:0]);
                if (!prev_we && bus_if.o_we_n && bus_if.o_cle) cmd_q.push_back(bus_if.o_dq[7:0]);
                if (!bus_if.o_dqs_tri_en && bus_if.o_dqs == 4'h5) data_q.push_back(bus_if.o_dq);
                if (bus_if.o_wready) wready_seen = 1;
                if (!bus_if.o_dqs_tri_en) dqs_drive_seen = 1;
                if (bus_if.o_status == 2'd2) stat2_seen = 1;
                if (bus_if.o_done) begin
                    done_cnt++;
                    last_id = bus_if.o_done_id;
                end
            end
            prev_we = bus_if.o_we_n;
        end
    end

    task automatic clear_mon();
        clr_gen++;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic [15:0] cmd, input logic [15:0] id,
                            input logic [47:0] addr, input logic [31:0] param);
        bit rdy = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus_if.o_cmd_ready) begin
                rdy = 1;
                break;
            end
        end
        check("cmd_ready_seen", 64'(rdy), 64'd1);
        bus_if.i_cmd       = cmd;
        bus_if.i_cmd_id    = id;
        bus_if.i_addr      = addr;
        bus_if.i_cmd_param = param;
        bus_if.i_cmd_valid = 1'b1;
        @(negedge clk);
        bus_if.i_cmd_valid = 1'b0;
    endtask

    task automatic run_data(input int n, input int stall_at, input int stall_len, output int k);
        bit started = 0;
        bit stalled = 0;
        int st = 0;
        k = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (bus_if.o_wready) started = 1;
            if (k == n || (started && !bus_if.o_wready)) break;
            if (!stalled && started && k == stall_at) begin
                stalled = 1;
                st = stall_len;
            end
            if (st > 0) begin
                bus_if.i_wvalid = 1'b0;
                if (st == 1) begin
                    check("stall_dqs_low", 64'(bus_if.o_dqs), 64'h0);
                    check("stall_dq_hold", 64'(bus_if.o_dq), 64'(words[k-1]));
                end
                st--;
            end else begin
                bus_if.i_wvalid = 1'b1;
                bus_if.i_wdata  = words[k];
                if (bus_if.o_wready) k++;
            end
        end
        bus_if.i_wvalid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit got = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done_cnt > 0) begin
                got = 1;
                break;
            end
        end
        check(tag, 64'(got), 64'd1);
    endtask

    task automatic rb_cycle(input string tag);
        bit got = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus_if.o_status == 2'd2) begin
                got = 1;
                break;
            end
        end
        check(tag, 64'(got), 64'd1);
        bus_if.i_rb_n = 1'b0;
        repeat (3) @(negedge clk);
        bus_if.i_rb_n = 1'b1;
        wait_done({tag, "_done"});
    endtask

    initial begin
        rst_n              = 1'b0;
        bus_if.i_cmd_valid = 1'b0;
        bus_if.i_cmd       = '0;
        bus_if.i_cmd_id    = '0;
        bus_if.i_addr      = '0;
        bus_if.i_cmd_param = '0;
        bus_if.i_wvalid    = 1'b0;
        bus_if.i_wdata     = '0;
        bus_if.i_rb_n      = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outs", pack_out(), RST_OUT);
        check("reset_dq", 64'(bus_if.o_dq), 64'h0);
        rst_n = 1'b1;

        // Program 80h/10h, 5 addr, 8 bytes, R/B_n tracking
        clear_mon();
        words[0] = 32'hDEADBEEF;
        words[1] = 32'h01234567;
        send_cmd(16'h1080, 16'hA55A, 48'h005544332211, 32'h0008_800B);
        run_data(2, -1, 0, acc);
        check("t1_words_acc", 64'(acc), 64'd2);
        rb_cycle("t1_lock");
        repeat (3) @(negedge clk);
        check("t1_ale_cycles", 64'(ale_cyc), 64'd40);
        check("t1_addr_count", 64'(addr_q.size()), 64'd5);
        for (int i = 0; i < 5; i++) check("t1_addr_byte", 64'(addr_q[i]), 64'(8'h11 * (i + 1)));
        check("t1_cmd_count", 64'(cmd_q.size()), 64'd2);
        check("t1_cmd_bytes", 64'({cmd_q[0], cmd_q[1]}), 64'h8010);
        check("t1_data_count", 64'(data_q.size()), 64'd2);
        check("t1_data0", 64'(data_q[0]), 64'hDEADBEEF);
        check("t1_data1", 64'(data_q[1]), 64'h01234567);
        check("t1_status_wait", 64'(stat2_seen), 64'd1);
        check("t1_done_once", 64'(done_cnt), 64'd1);
        check("t1_done_id", 64'(last_id), 64'hA55A);

        // Stall after two words for three clocks, 16 bytes, fixed busy 0
        clear_mon();
        words[0] = 32'h11111111;
        words[1] = 32'h22222222;
        words[2] = 32'h33333333;
        words[3] = 32'h44444444;
        send_cmd(16'h0080, 16'h0202, 48'h0000000000AB, 32'h0010_0002);
        run_data(4, 2, 3, acc);
        wait_done("t2_done");
        check("t2_words_acc", 64'(acc), 64'd4);
        check("t2_data_count", 64'(data_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) check("t2_data_word", 64'(data_q[i]), 64'(words[i]));
        check("t2_done_id", 64'(last_id), 64'h0202);

        // Erase 60h/D0h, 3 addr, no data
        clear_mon();
        send_cmd(16'hD060, 16'h0E0E, 48'h000000CCBBAA, 32'h0000_8007);
        rb_cycle("t3_lock");
        repeat (3) @(negedge clk);
        check("t3_no_wready", 64'(wready_seen), 64'd0);
        check("t3_dqs_tristate", 64'(dqs_drive_seen), 64'd0);
        check("t3_cmd_bytes", 64'({cmd_q[0], cmd_q[1]}), 64'h60D0);
        check("t3_addr_count", 64'(addr_q.size()), 64'd3);
        check("t3_addr_last", 64'(addr_q[2]), 64'hCC);
        check("t3_done_id", 64'(last_id), 64'h0E0E);

        // Fixed busy of 5 clocks, no CMD2, R/B_n held low and ignored
        clear_mon();
        bus_if.i_rb_n = 1'b0;
        send_cmd(16'h0085, 16'h0044, 48'h000000002211, 32'h0000_0054);
        wait_done("t4_done");
        repeat (5) @(negedge clk);
        check("t4_busy_cycles", 64'(busy_cyc), 64'd5);
        check("t4_done_once", 64'(done_cnt), 64'd1);
        check("t4_ale_cycles", 64'(ale_cyc), 64'd16);
        bus_if.i_rb_n = 1'b1;

        // Reset in the middle of DATA
        clear_mon();
        send_cmd(16'h0080, 16'h0BAD, 48'h0, 32'h0010_0000);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus_if.o_wready) begin
                ok = 1;
                break;
            end
        end
        check("t5_data_reached", 64'(ok), 64'd1);
        bus_if.i_wvalid = 1'b1;
        bus_if.i_wdata  = 32'hCAFEF00D;
        @(negedge clk);
        check("t5_word_out", 64'(bus_if.o_dq), 64'hCAFEF00D);
        rst_n = 1'b0;
        #1;
        check("t5_rst_outs", pack_out(), RST_OUT);
        check("t5_rst_dq", 64'(bus_if.o_dq), 64'h0);
        bus_if.i_wvalid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("t5_no_done", 64'(done_cnt), 64'd0);

        // 6 bytes, no address: exactly two words taken
        clear_mon();
        words[0] = 32'hA0A0A0A0;
        words[1] = 32'hB1B1B1B1;
        words[2] = 32'hC2C2C2C2;
        send_cmd(16'h0080, 16'h0606, 48'h0, 32'h0006_0000);
        run_data(3, -1, 0, acc);
        wait_done("t6_done");
        check("t6_words_acc", 64'(acc), 64'd2);
        check("t6_data_count", 64'(data_q.size()), 64'd2);
        check("t6_data0", 64'(data_q[0]), 64'hA0A0A0A0);
        check("t6_data1", 64'(data_q[1]), 64'hB1B1B1B1);
        check("t6_done_id", 64'(last_id), 64'h0606);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
